bus_wait_ctrl: RTL and testbench

BUS_WAIT_CTRL -- requirements
Module: bus_wait_ctrl

---
 rtl/bus_wait_ctrl.sv | 108 ++++++++++
 tb/tb_bus_wait_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// Wait-state bus controller: latches an MPU access, holds it on the memory port until
// MEM_ACK or a cycle-count timeout, then presents a one-cycle RDY with registered read data.
module bus_wait_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [15:0] AB,
  input  logic        R_W,
  input  logic [7:0]  DB_OUT,
  output logic [7:0]  DB_IN,
  output logic        RDY,
  output logic        MEM_REQ,
  output logic [15:0] MEM_A,
  output logic        MEM_WE,
  output logic [7:0]  MEM_WD,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RD,
  output logic        ERR
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_a_q, mem_a_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wd_q, mem_wd_d;
  logic [7:0]  db_in_q, db_in_d;
  logic        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    mem_a_d   = mem_a_q;
    mem_we_d  = mem_we_q;
    mem_wd_d  = mem_wd_q;
    db_in_d   = db_in_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        mem_a_d   = AB;
        mem_we_d  = ~R_W;
        mem_wd_d  = DB_OUT;
        mem_req_d = 1'b1;
        cnt_d     = 8'd0;
        state_d   = StWait;
      end
      StWait: begin
        // An ack always wins, even on the cycle the counter would expire.
        if (MEM_ACK) begin
          if (!mem_we_q) db_in_d = MEM_RD;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutCnt) begin
            if (!mem_we_q) db_in_d = 8'hFF;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      mem_req_q <= 1'b0;
      mem_a_q   <= 16'h0000;
      mem_we_q  <= 1'b0;
      mem_wd_q  <= 8'h00;
      db_in_q   <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_a_q   <= mem_a_d;
      mem_we_q  <= mem_we_d;
      mem_wd_q  <= mem_wd_d;
      db_in_q   <= db_in_d;
      err_q     <= err_d;
    end
  end

  assign RDY     = (state_q == StDone);
  assign MEM_REQ = mem_req_q;
  assign MEM_A   = mem_a_q;
  assign MEM_WE  = mem_we_q;
  assign MEM_WD  = mem_wd_q;
  assign DB_IN   = db_in_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed self-checking bench for bus_wait_ctrl with TIMEOUT=15.
module tb_bus_wait_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] ab;
  logic        r_w;
  logic [7:0]  db_out;
  logic [7:0]  db_in;
  logic        rdy;
  logic        mem_req;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic        mem_ack;
  logic [7:0]  mem_rd;
  logic        err;

  int checks   = 0;
  int failures = 0;

  bus_wait_ctrl #(.TIMEOUT(15)) dut (
    .CLK    (clk),
    .RES    (res),
    .AB     (ab),
    .R_W    (r_w),
    .DB_OUT (db_out),
    .DB_IN  (db_in),
    .RDY    (rdy),
    .MEM_REQ(mem_req),
    .MEM_A  (mem_a),
    .MEM_WE (mem_we),
    .MEM_WD (mem_wd),
    .MEM_ACK(mem_ack),
    .MEM_RD (mem_rd),
    .ERR    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE, ends in the DONE cycle. Returns total access latency (0 if RDY never came),
  // and whether MEM_A/MEM_REQ held during every WAIT cycle. Bus inputs are scrambled during WAIT.
  task automatic run_access(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                            input int ack_at, input logic [7:0] rd,
                            output int lat, output logic a_stable, output logic req_held);
    ab = addr; r_w = rw; db_out = wd;
    tick();
    lat = 0; a_stable = 1'b1; req_held = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      if (mem_a !== addr) a_stable = 1'b0;
      if (mem_req !== 1'b1) req_held = 1'b0;
      ab = ~addr; r_w = ~rw; db_out = ~wd;
      if (k == ack_at) begin
        mem_ack = 1'b1;
        mem_rd  = rd;
      end
      tick();
      mem_ack = 1'b0;
      if (rdy === 1'b1) begin
        lat = k + 2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b1; ab = 16'h0; r_w = 1'b1; db_out = 8'h0; mem_ack = 1'b0; mem_rd = 8'h0;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, rdy, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: req/we/rdy/err=%b want 0000", {mem_req, mem_we, rdy, err});
    end
    checks++;
    if ({mem_a, mem_wd, db_in} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: a=%h wd=%h db_in=%h want 0", mem_a, mem_wd, db_in);
    end
    res = 1'b0;
  endtask

  task automatic test_read();
    int lat; logic st; logic rh;
    run_access(16'h1234, 1'b1, 8'h00, 1, 8'hA5, lat, st, rh);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++;
    if (db_in !== 8'hA5) begin failures++; $display("FAIL read_data: got %h want a5", db_in); end
    checks++;
    if (mem_a !== 16'h1234 || !st || !rh) begin
      failures++;
      $display("FAIL read_addr: a=%h stable=%b req=%b want 1234 1 1", mem_a, st, rh);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL read_we_req: we=%b req=%b want 0 0", mem_we, mem_req);
    end
    tick();
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL read_rdy_width: rdy=%b want 0", rdy); end
  endtask

  task automatic test_write();
    int lat; logic st; logic rh;
    run_access(16'h0200, 1'b0, 8'h3C, 4, 8'h99, lat, st, rh);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL write_latency: got %0d want 6", lat); end
    checks++;
    if (mem_we !== 1'b1 || mem_wd !== 8'h3C || mem_a !== 16'h0200 || !st) begin
      failures++;
      $display("FAIL write_latch: we=%b wd=%h a=%h stable=%b want 1 3c 0200 1",
               mem_we, mem_wd, mem_a, st);
    end
    checks++;
    if (db_in !== 8'hA5) begin failures++; $display("FAIL write_db_in: got %h want a5", db_in); end
    tick();
  endtask

  task automatic test_ack_at_timeout();
    int lat; logic st; logic rh;
    run_access(16'h0010, 1'b1, 8'h00, 15, 8'h5C, lat, st, rh);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL coinc_latency: got %0d want 17", lat); end
    checks++;
    if (db_in !== 8'h5C || err !== 1'b0) begin
      failures++;
      $display("FAIL coinc_data_err: db_in=%h err=%b want 5c 0", db_in, err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int lat; logic st; logic rh;
    run_access(16'h0020, 1'b1, 8'h00, 0, 8'h00, lat, st, rh);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL tmo_latency: got %0d want 17", lat); end
    checks++;
    if (db_in !== 8'hFF || err !== 1'b1 || mem_req !== 1'b0 || !rh) begin
      failures++;
      $display("FAIL tmo_result: db_in=%h err=%b req=%b held=%b want ff 1 0 1",
               db_in, err, mem_req, rh);
    end
    // Late ack during DONE must not touch DB_IN.
    mem_ack = 1'b1; mem_rd = 8'h11;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (db_in !== 8'hFF || rdy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_late_ack: db_in=%h rdy=%b want ff 0", db_in, rdy);
    end
    run_access(16'h0300, 1'b1, 8'h00, 1, 8'h66, lat, st, rh);
    checks++;
    if (db_in !== 8'h66 || err !== 1'b1 || lat !== 3) begin
      failures++;
      $display("FAIL tmo_sticky: db_in=%h err=%b lat=%0d want 66 1 3", db_in, err, lat);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    ab = 16'h0040; r_w = 1'b1; db_out = 8'h00;
    tick();
    tick();
    // Second WAIT cycle: reset together with an ack.
    res = 1'b1; mem_ack = 1'b1; mem_rd = 8'h77;
    tick();
    checks++;
    if (mem_req !== 1'b0 || db_in !== 8'h00 || rdy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait: req=%b db_in=%h rdy=%b err=%b want 0 00 0 0",
               mem_req, db_in, rdy, err);
    end
    res = 1'b0; ab = 16'h0041;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_a !== 16'h0041 || db_in !== 8'h00 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_restart: req=%b a=%h db_in=%h rdy=%b want 1 0041 00 0",
               mem_req, mem_a, db_in, rdy);
    end
    mem_ack = 1'b1; mem_rd = 8'h22;
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic st; logic rh;
    run_access(16'hFFFE, 1'b1, 8'h00, 1, 8'h5A, lat, st, rh);
    checks++;
    if (db_in !== 8'h5A || mem_a !== 16'hFFFE || !st || lat !== 3) begin
      failures++;
      $display("FAIL b2b_first: db_in=%h a=%h stable=%b lat=%0d want 5a fffe 1 3",
               db_in, mem_a, st, lat);
    end
    tick();
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL b2b_gap: rdy=%b want 0", rdy); end
    run_access(16'hFFFF, 1'b1, 8'h00, 2, 8'hC3, lat, st, rh);
    checks++;
    if (db_in !== 8'hC3 || mem_a !== 16'hFFFF || !st || lat !== 4) begin
      failures++;
      $display("FAIL b2b_second: db_in=%h a=%h stable=%b lat=%0d want c3 ffff 1 4",
               db_in, mem_a, st, lat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ack_at_timeout();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
